// File: rtl/wb2axip_fifo2axis.sv
//------------------------------------------------------------------------------
// Module      : wb2axip_fifo2axis
// Description : FIFO-to-AXI-stream drain stage with registered output, a
//               one-entry skid buffer and TLAST packetisation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb2axip_fifo2axis #(
    parameter int BW    = 8,
    parameter int LGPKT = 8,
    parameter int CNTW  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [LGPKT-1:0] i_pktlen_m1,
    output logic             o_fifo_rd,
    input  logic [BW-1:0]    i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [BW-1:0]    M_AXIS_TDATA,
    output logic             M_AXIS_TLAST,
    output logic             o_busy,
    output logic             o_pkt_done,
    output logic [CNTW-1:0]  o_pkts
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LGPKT-1:0]  beat_q, beat_d;
    logic [LGPKT-1:0]  len_q, len_d;
    logic              tvalid_q, tvalid_d;
    logic [BW-1:0]     tdata_q, tdata_d;
    logic              tlast_q, tlast_d;
    logic              skid_valid_q, skid_valid_d;
    logic [BW-1:0]     skid_data_q, skid_data_d;
    logic              skid_last_q, skid_last_d;
    logic              pkt_done_q, pkt_done_d;
    logic [CNTW-1:0]   pkts_q, pkts_d;

    logic w_run;
    logic w_rd;
    logic w_last;
    logic w_accept;

    // The read strobe is built only from state and FIFO status so TREADY
    // never reaches the FIFO combinationally; the skid absorbs the overrun.
    assign w_run    = (state_q == S_ACTIVE) || ((state_q == S_IDLE) && i_enable);
    assign w_rd     = w_run && !i_fifo_empty && !skid_valid_q && !i_reset;
    assign w_accept = tvalid_q && M_AXIS_TREADY;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        w_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_last = (i_pktlen_m1 == '0);
                if (w_rd) begin
                    len_d  = i_pktlen_m1;
                    beat_d = LGPKT'(1);
                    if (!w_last)
                        state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                w_last = (beat_q == len_q);
                if (w_rd) begin
                    beat_d = beat_q + 1'b1;
                    if (w_last)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (!tvalid_q || M_AXIS_TREADY) begin
            // Output register is free: skid beat is older, so it goes first.
            if (skid_valid_q) begin
                tvalid_d     = 1'b1;
                tdata_d      = skid_data_q;
                tlast_d      = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (w_rd) begin
                tvalid_d = 1'b1;
                tdata_d  = i_fifo_data;
                tlast_d  = w_last;
            end else begin
                tvalid_d = 1'b0;
            end
        end else if (w_rd) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_fifo_data;
            skid_last_d  = w_last;
        end
        pkt_done_d = w_accept && tlast_q;
        pkts_d     = pkts_q + CNTW'(w_accept && tlast_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            len_q        <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkts_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            pkt_done_q   <= pkt_done_d;
            pkts_q       <= pkts_d;
        end
    end

    assign o_fifo_rd     = w_rd;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign o_busy        = (state_q == S_ACTIVE) || tvalid_q || skid_valid_q;
    assign o_pkt_done    = pkt_done_q;
    assign o_pkts        = pkts_q;

endmodule

`default_nettype wire
